// File: rtl/fft_stage_sequencer_if.sv
// fft_stage_sequencer_if: start/done handshake plus RAM bank and twiddle ROM control
interface fft_stage_sequencer_if #(parameter int N_LOG2 = 10);
   logic                      start;
   logic                      busy;
   logic                      done;
   logic [$clog2(N_LOG2)-1:0] stage;
   logic                      rd_en;
   logic                      rd_bank;
   logic [N_LOG2-1:0]         rd_addr_a;
   logic [N_LOG2-1:0]         rd_addr_b;
   logic [N_LOG2-2:0]         tw_addr;
   logic                      wr_en;
   logic                      wr_bank;
   logic [N_LOG2-1:0]         wr_addr_a;
   logic [N_LOG2-1:0]         wr_addr_b;
   modport master (output start, input busy, done, stage, rd_en, rd_bank, rd_addr_a, rd_addr_b,
                   tw_addr, wr_en, wr_bank, wr_addr_a, wr_addr_b);
   modport slave (input start, output busy, done, stage, rd_en, rd_bank, rd_addr_a, rd_addr_b,
                  tw_addr, wr_en, wr_bank, wr_addr_a, wr_addr_b);
endinterface

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: in-place radix-2 DIT FFT address sequencer with write-back delay line
module fft_stage_sequencer #(
   parameter int N_LOG2   = 10,
   parameter int BFLY_LAT = 4
) (
   input logic                 clk,
   input logic                 rst,
   fft_stage_sequencer_if.slave bus
);
   localparam int SW = $clog2(N_LOG2);
   localparam int JW = N_LOG2 - 1;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
   typedef struct packed {
      logic              v;
      logic              bank;
      logic [N_LOG2-1:0] a;
      logic [N_LOG2-1:0] b;
   } wr_t;
   state_t            state_q, state_d;
   logic [SW-1:0]     s_q, s_d;
   logic [JW-1:0]     j_q, j_d;
   logic              done_q, done_d;
   wr_t               pipe_q [BFLY_LAT];
   wr_t               rd;
   logic              issue, last_stage;
   logic [N_LOG2-1:0] half, pos, addr_a;
   logic [JW-1:0]     tw;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= '0;
         j_q     <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < BFLY_LAT; i++) pipe_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         s_q       <= s_d;
         j_q       <= j_d;
         done_q    <= done_d;
         pipe_q[0] <= rd;
         for (int i = 1; i < BFLY_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end
   // j doubles as the drain counter so DRAIN needs no extra register
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      j_d     = j_q + 1'b1;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            j_d     = '0;
            state_d = bus.start ? ISSUE : IDLE;
         end
         ISSUE: state_d = (&j_q) ? DRAIN : ISSUE;
         DRAIN: if (j_q == JW'(BFLY_LAT - 1)) begin
            j_d     = '0;
            state_d = last_stage ? IDLE : ISSUE;
            s_d     = last_stage ? '0 : s_q + 1'b1;
            done_d  = last_stage;
         end
         default: state_d = IDLE;
      endcase
   end
   assign last_stage = s_q == SW'(N_LOG2 - 1);
   assign issue      = state_q == ISSUE;
   assign half       = N_LOG2'(1) << s_q;
   assign pos        = N_LOG2'(j_q) & (half - 1'b1);
   assign addr_a     = ((N_LOG2'(j_q) >> s_q) << (s_q + 1'b1)) | pos;
   assign tw         = JW'(pos << (SW'(N_LOG2 - 1) - s_q));
   assign rd         = '{v: issue, bank: issue & ~s_q[0], a: issue ? addr_a : '0,
                         b: issue ? (addr_a | half) : '0};
   assign bus.busy      = state_q != IDLE;
   assign bus.done      = done_q;
   assign bus.stage     = s_q;
   assign bus.rd_en     = issue;
   assign bus.rd_bank   = issue & s_q[0];
   assign bus.rd_addr_a = rd.a;
   assign bus.rd_addr_b = rd.b;
   assign bus.tw_addr   = issue ? tw : '0;
   assign bus.wr_en     = pipe_q[BFLY_LAT-1].v;
   assign bus.wr_bank   = pipe_q[BFLY_LAT-1].bank;
   assign bus.wr_addr_a = pipe_q[BFLY_LAT-1].a;
   assign bus.wr_addr_b = pipe_q[BFLY_LAT-1].b;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed checks plus a per-cycle reference of the full sequence
module tb_fft_stage_sequencer;
   localparam int NL = 10, LAT = 4, H = 512, P = H + LAT, TOT = NL * P;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors = 0, miscompares = 0, tcyc = 0;
   bit   model_on = 1'b0;
   logic [58:0] obs, exp_v;
   always #5 clk = ~clk;
   fft_stage_sequencer_if #(.N_LOG2(NL)) bus();
   fft_stage_sequencer #(.N_LOG2(NL), .BFLY_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
   function automatic logic [58:0] model(input int c);
      int busy = 0, done = 0, st = 0, off = 0, hf = 1, pos = 0, j = 0;
      int re = 0, rbk = 0, ra = 0, rb = 0, tw = 0, we = 0, wbk = 0, wa = 0, wb = 0;
      done = (c == TOT + 1) ? 1 : 0;
      if (c >= 1 && c <= TOT) begin
         busy = 1;
         st   = (c - 1) / P;
         off  = (c - 1) % P;
         hf   = 1 << st;
         if (off < H) begin
            re  = 1;
            rbk = st % 2;
            pos = off % hf;
            ra  = (off / hf) * 2 * hf + pos;
            rb  = ra + hf;
            tw  = (pos * (1 << (NL - 1 - st))) % H;
         end
         if (off >= LAT) begin
            j   = off - LAT;
            we  = 1;
            wbk = 1 - st % 2;
            pos = j % hf;
            wa  = (j / hf) * 2 * hf + pos;
            wb  = wa + hf;
         end
      end
      return {1'(busy), 1'(done), 4'(st), 1'(re), 1'(rbk), 10'(ra), 10'(rb), 9'(tw),
              1'(we), 1'(wbk), 10'(wa), 10'(wb)};
   endfunction
   task automatic step();
      bit acc;
      acc = bus.start && !rst && !(tcyc >= 1 && tcyc <= TOT);
      @(posedge clk);
      #1;
      tcyc = rst ? 0 : acc ? 1 : (tcyc == 0 || tcyc > TOT) ? 0 : tcyc + 1;
      if (model_on) begin
         obs = {bus.busy, bus.done, bus.stage, bus.rd_en, bus.rd_bank, bus.rd_addr_a, bus.rd_addr_b,
                bus.tw_addr, bus.wr_en, bus.wr_bank, bus.wr_addr_a, bus.wr_addr_b};
         exp_v = model(tcyc);
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL seq_cycle_%0d: got %h want %h", tcyc, obs, exp_v);
         end
      end
   endtask
   task automatic goto(input int c);
      for (int k = 0; k < 6000 && tcyc != c; k++) step();
      vectors++;
      if (tcyc != c) begin
         miscompares++;
         $display("FAIL goto: reached %0d want %0d", tcyc, c);
      end
   endtask
   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      rst = 1'b0;
      model_on = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         vectors++;
         if ({bus.busy, bus.done, bus.stage, bus.rd_en, bus.rd_bank, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr,
              bus.wr_en, bus.wr_bank, bus.wr_addr_a, bus.wr_addr_b} !== 59'd0) begin
            miscompares++;
            $display("FAIL reset_idle_%0d: busy=%b done=%b rd_en=%b wr_en=%b want all 0",
                     i, bus.busy, bus.done, bus.rd_en, bus.wr_en);
         end
      end
   endtask
   task automatic test_stage0();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      vectors++;
      if ({bus.rd_en, bus.rd_bank, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.stage, bus.busy} !==
          {1'b1, 1'b0, 10'd0, 10'd1, 9'd0, 4'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL s0_c1: rd_en=%b bank=%b a=%0d b=%0d tw=%0d want 1 0 0 1 0",
                  bus.rd_en, bus.rd_bank, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr);
      end
      step();
      vectors++;
      if ({bus.rd_addr_a, bus.rd_addr_b} !== {10'd2, 10'd3}) begin
         miscompares++;
         $display("FAIL s0_c2: a=%0d b=%0d want 2 3", bus.rd_addr_a, bus.rd_addr_b);
      end
      goto(4);
      vectors++;
      if (bus.wr_en !== 1'b0) begin
         miscompares++;
         $display("FAIL s0_c4_nowr: wr_en=%b want 0", bus.wr_en);
      end
      goto(5);
      vectors++;
      if ({bus.wr_en, bus.wr_bank, bus.wr_addr_a, bus.wr_addr_b} !== {1'b1, 1'b1, 10'd0, 10'd1}) begin
         miscompares++;
         $display("FAIL s0_c5_wr: en=%b bank=%b a=%0d b=%0d want 1 1 0 1",
                  bus.wr_en, bus.wr_bank, bus.wr_addr_a, bus.wr_addr_b);
      end
      goto(512);
      vectors++;
      if ({bus.rd_en, bus.rd_addr_a, bus.rd_addr_b} !== {1'b1, 10'd1022, 10'd1023}) begin
         miscompares++;
         $display("FAIL s0_c512: en=%b a=%0d b=%0d want 1 1022 1023", bus.rd_en, bus.rd_addr_a, bus.rd_addr_b);
      end
      for (int c = 513; c <= 516; c++) begin
         goto(c);
         vectors++;
         if (bus.rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_c%0d: rd_en=%b want 0", c, bus.rd_en);
         end
      end
      vectors++;
      if ({bus.wr_en, bus.wr_bank, bus.wr_addr_a, bus.wr_addr_b} !== {1'b1, 1'b1, 10'd1022, 10'd1023}) begin
         miscompares++;
         $display("FAIL s0_lastwr: en=%b bank=%b a=%0d b=%0d want 1 1 1022 1023",
                  bus.wr_en, bus.wr_bank, bus.wr_addr_a, bus.wr_addr_b);
      end
   endtask
   task automatic test_stage1();
      goto(517);
      vectors++;
      if ({bus.stage, bus.rd_bank, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr} !==
          {4'd1, 1'b1, 10'd0, 10'd2, 9'd0}) begin
         miscompares++;
         $display("FAIL s1_c517: stage=%0d bank=%b a=%0d b=%0d tw=%0d want 1 1 0 2 0",
                  bus.stage, bus.rd_bank, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr);
      end
      step();
      vectors++;
      if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr} !== {10'd1, 10'd3, 9'd256}) begin
         miscompares++;
         $display("FAIL s1_c518: a=%0d b=%0d tw=%0d want 1 3 256", bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr);
      end
      step();
      vectors++;
      if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr} !== {10'd4, 10'd6, 9'd0}) begin
         miscompares++;
         $display("FAIL s1_c519: a=%0d b=%0d tw=%0d want 4 6 0", bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr);
      end
   endtask
   task automatic test_ignored_start();
      goto(3000);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      vectors++;
      if ({bus.busy, bus.stage, bus.rd_en} !== {1'b1, 4'd5, 1'b1}) begin
         miscompares++;
         $display("FAIL busy_start: busy=%b stage=%0d rd_en=%b want 1 5 1", bus.busy, bus.stage, bus.rd_en);
      end
   endtask
   task automatic test_stage9_done();
      goto(4645);
      vectors++;
      if ({bus.stage, bus.rd_bank, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr} !==
          {4'd9, 1'b1, 10'd0, 10'd512, 9'd0}) begin
         miscompares++;
         $display("FAIL s9_c4645: stage=%0d bank=%b a=%0d b=%0d tw=%0d want 9 1 0 512 0",
                  bus.stage, bus.rd_bank, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr);
      end
      step();
      vectors++;
      if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr} !== {10'd1, 10'd513, 9'd1}) begin
         miscompares++;
         $display("FAIL s9_c4646: a=%0d b=%0d tw=%0d want 1 513 1", bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr);
      end
      goto(5156);
      vectors++;
      if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr} !== {10'd511, 10'd1023, 9'd511}) begin
         miscompares++;
         $display("FAIL s9_last_rd: a=%0d b=%0d tw=%0d want 511 1023 511", bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr);
      end
      goto(5160);
      vectors++;
      if ({bus.busy, bus.done, bus.wr_en, bus.wr_bank, bus.wr_addr_a, bus.wr_addr_b} !==
          {1'b1, 1'b0, 1'b1, 1'b0, 10'd511, 10'd1023}) begin
         miscompares++;
         $display("FAIL final_wr: busy=%b done=%b en=%b bank=%b a=%0d b=%0d want 1 0 1 0 511 1023",
                  bus.busy, bus.done, bus.wr_en, bus.wr_bank, bus.wr_addr_a, bus.wr_addr_b);
      end
      goto(5161);
      vectors++;
      if ({bus.busy, bus.done, bus.wr_en, bus.stage} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
         miscompares++;
         $display("FAIL done_c5161: busy=%b done=%b wr_en=%b stage=%0d want 0 1 0 0",
                  bus.busy, bus.done, bus.wr_en, bus.stage);
      end
   endtask
   task automatic test_back_to_back();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      vectors++;
      if ({bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.stage, bus.done, bus.busy} !==
          {1'b1, 10'd0, 10'd1, 4'd0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL back_to_back: rd_en=%b a=%0d b=%0d stage=%0d done=%b busy=%b want 1 0 1 0 0 1",
                  bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.stage, bus.done, bus.busy);
      end
   endtask
   task automatic test_mid_reset();
      goto(300);
      rst = 1'b1;
      step();
      rst = 1'b0;
      vectors++;
      if ({bus.busy, bus.done, bus.rd_en, bus.wr_en} !== 4'd0) begin
         miscompares++;
         $display("FAIL mid_reset: busy=%b done=%b rd_en=%b wr_en=%b want 0 0 0 0",
                  bus.busy, bus.done, bus.rd_en, bus.wr_en);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         vectors++;
         if (bus.wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL flushed_wr_%0d: wr_en=%b want 0", i, bus.wr_en);
         end
      end
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      goto(TOT);
      vectors++;
      if ({bus.busy, bus.done} !== 2'b10) begin
         miscompares++;
         $display("FAIL rerun_c5160: busy=%b done=%b want 1 0", bus.busy, bus.done);
      end
      step();
      vectors++;
      if ({bus.busy, bus.done} !== 2'b01) begin
         miscompares++;
         $display("FAIL rerun_done: busy=%b done=%b want 0 1", bus.busy, bus.done);
      end
      step();
      step();
   endtask
   initial begin
      bus.start = 1'b0;
      test_reset();
      test_stage0();
      test_stage1();
      test_ignored_start();
      test_stage9_done();
      test_back_to_back();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
